// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard: per-register countdowns until a result is forwardable to ID,
// stall generation, and one-cycle undo for the branch-squashed issue. Optional perf counters: SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int CW       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_we,
    input  logic        issue_is_load,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_rs1_used,
    input  logic        issue_rs2_used,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] busy_mask
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_load_stalls
`endif
);

    localparam logic [CW-1:0] ALU_CNT  = CW'(ALU_LAT);
    localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_LAT);

    logic [CW-1:0] cnt_q [32];
    logic [CW-1:0] cnt_d [32];
    logic          last_valid_q, last_valid_d;
    logic [4:0]    last_rd_q, last_rd_d;
    logic [CW-1:0] last_prev_q, last_prev_d;
    logic          rs1_busy, rs2_busy, issue_fire;

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - CW'(1);
    endfunction

    always_comb begin
        rs1_busy   = issue_rs1_used && (issue_rs1 != 5'd0) && (cnt_q[issue_rs1] != '0);
        rs2_busy   = issue_rs2_used && (issue_rs2 != 5'd0) && (cnt_q[issue_rs2] != '0);
        stall      = issue_valid && !flush && (rs1_busy || rs2_busy);
        issue_fire = issue_valid && !stall && !flush && issue_we && (issue_rd != 5'd0);
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < 32; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    // Later assignments override earlier ones: free-running decrement, then undo, then new issue.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = sat_dec(cnt_q[r]);
        end
        if (flush && last_valid_q) begin
            cnt_d[last_rd_q] = sat_dec(last_prev_q);
        end
        if (issue_fire) begin
            cnt_d[issue_rd] = issue_is_load ? LOAD_CNT : ALU_CNT;
        end
        cnt_d[0] = '0;

        last_valid_d = issue_fire;
        last_rd_d    = last_rd_q;
        last_prev_d  = last_prev_q;
        if (issue_fire) begin
            last_rd_d   = issue_rd;
            last_prev_d = cnt_q[issue_rd];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            last_valid_q <= 1'b0;
            last_rd_q    <= '0;
            last_prev_q  <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            last_valid_q <= last_valid_d;
            last_rd_q    <= last_rd_d;
            last_prev_q  <= last_prev_d;
        end
    end

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] is_load_q, is_load_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_load_q, perf_load_d;
    logic        load_blocked;

    always_comb begin
        is_load_d = is_load_q;
        if (issue_fire) begin
            is_load_d[issue_rd] = issue_is_load;
        end
        load_blocked = (rs1_busy && is_load_q[issue_rs1]) || (rs2_busy && is_load_q[issue_rs2]);
        perf_stall_d = stall ? perf_stall_q + 32'd1 : perf_stall_q;
        perf_load_d  = (stall && load_blocked) ? perf_load_q + 32'd1 : perf_load_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_load_q    <= '0;
            perf_stall_q <= '0;
            perf_load_q  <= '0;
        end else begin
            is_load_q    <= is_load_d;
            perf_stall_q <= perf_stall_d;
            perf_load_q  <= perf_load_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_load_stalls  = perf_load_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic checked against a
// ready-time model (each register holds the absolute cycle at which it becomes forwardable).
module tb_hazard_scoreboard;
    localparam int ALU_LAT  = 1;
    localparam int LOAD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0, issue_we = 1'b0, issue_is_load = 1'b0;
    logic [4:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic        issue_rs1_used = 1'b0, issue_rs2_used = 1'b0, flush = 1'b0;
    logic        stall;
    logic [31:0] busy_mask;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_load_stalls;
`endif

    hazard_scoreboard #(.ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .CW(3)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
        .issue_is_load(issue_is_load), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .flush(flush), .stall(stall), .busy_mask(busy_mask)
`ifdef SCOREBOARD_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_load_stalls(perf_load_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int now = 0;
    int ready_at [32];
    bit isl [32];
    bit m_lv;
    int m_lrd, m_lprev;
    int m_pstall, m_pload;

    function automatic bit m_busy(input int r);
        return (r != 0) && (ready_at[r] > now);
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int r = 1; r < 32; r++) m[r] = m_busy(r);
        return m;
    endfunction

    function automatic bit m_stall();
        return issue_valid && !flush &&
               ((issue_rs1_used && m_busy(int'(issue_rs1))) || (issue_rs2_used && m_busy(int'(issue_rs2))));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            ready_at[r] = 0;
            isl[r] = 1'b0;
        end
        m_lv = 1'b0; m_lrd = 0; m_lprev = 0;
        m_pstall = 0; m_pload = 0;
    endtask

    // Advance model by one clock using the currently driven inputs, then step the DUT.
    task automatic cycle();
        bit s, fire;
        int rd, s1, s2;
        rd = int'(issue_rd); s1 = int'(issue_rs1); s2 = int'(issue_rs2);
        s = m_stall();
        fire = issue_valid && !s && !flush && issue_we && (rd != 0);
        if (s) begin
            m_pstall++;
            if ((issue_rs1_used && m_busy(s1) && isl[s1]) || (issue_rs2_used && m_busy(s2) && isl[s2]))
                m_pload++;
        end
        if (flush && m_lv)
            ready_at[m_lrd] = now + 1 + ((m_lprev > 0) ? m_lprev - 1 : 0);
        if (fire) begin
            m_lprev = (ready_at[rd] > now) ? ready_at[rd] - now : 0;
            ready_at[rd] = now + 1 + (issue_is_load ? LOAD_LAT : ALU_LAT);
            isl[rd] = issue_is_load;
            m_lv = 1'b1;
            m_lrd = rd;
        end else begin
            m_lv = 1'b0;
        end
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic drv(input bit v, input int d, input bit w, input bit l,
                       input int s1, input int s2, input bit a1, input bit a2, input bit f);
        logic [31:0] d32, s1_32, s2_32;
        d32 = d; s1_32 = s1; s2_32 = s2;
        issue_valid = v; issue_rd = d32[4:0]; issue_we = w; issue_is_load = l;
        issue_rs1 = s1_32[4:0]; issue_rs2 = s2_32[4:0];
        issue_rs1_used = a1; issue_rs2_used = a2; flush = f;
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 31), $urandom_range(0, 31), 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (stall !== 1'b0 || busy_mask !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_hold: stall=%b busy=%h want stall=0 busy=0", stall, busy_mask);
            end
`ifdef SCOREBOARD_PERF_EN
            n_checks++;
            if (perf_stall_cycles !== 32'd0 || perf_load_stalls !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_stall_cycles, perf_load_stalls);
            end
`endif
            @(posedge clk);
            #1;
        end
        idle();
        rst = 1'b0;
        model_reset();
        // reset asserted mid-stall must drop stall without a clock edge
        drv(1, 5, 1, 1, 0, 0, 0, 0, 0); cycle();
        drv(1, 6, 1, 0, 5, 0, 1, 0, 0);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prestall: stall=%b want 1", stall);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0 || busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: stall=%b busy=%h want 0/0", stall, busy_mask);
        end
        do_reset();
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0); cycle();
        idle();
        n_checks++;
        if (busy_mask !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL reset_first_issue: busy=%h want 00000020", busy_mask);
        end
    endtask

    task automatic test_alu_use();
`ifdef SCOREBOARD_PERF_EN
        logic [31:0] p_s, p_l;
`endif
        do_reset();
`ifdef SCOREBOARD_PERF_EN
        p_s = perf_stall_cycles; p_l = perf_load_stalls;
`endif
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_c0: stall=%b want 0", stall); end
        cycle();
        drv(1, 6, 1, 0, 5, 0, 1, 0, 0);
        n_checks++;
        if (stall !== 1'b1 || busy_mask !== 32'h20) begin
            n_fail++; $display("FAIL alu_c1: stall=%b busy=%h want 1/00000020", stall, busy_mask);
        end
        cycle();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_c2: stall=%b want 0", stall); end
        cycle();
        idle();
        n_checks++;
        if (busy_mask !== 32'h40) begin n_fail++; $display("FAIL alu_c3_mask: busy=%h want 00000040", busy_mask); end
        drv(1, 10, 1, 0, 0, 0, 0, 0, 0); cycle();
        drv(1, 11, 1, 0, 0, 0, 0, 0, 0); cycle();
        drv(1, 12, 1, 0, 10, 0, 1, 0, 0);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_gap1: stall=%b want 0", stall); end
        cycle();
        idle();
`ifdef SCOREBOARD_PERF_EN
        n_checks++;
        if (perf_stall_cycles - p_s !== 32'd1 || perf_load_stalls - p_l !== 32'd0) begin
            n_fail++;
            $display("FAIL alu_perf: delta %0d/%0d want 1/0", perf_stall_cycles - p_s, perf_load_stalls - p_l);
        end
`endif
    endtask

    task automatic test_load_use();
`ifdef SCOREBOARD_PERF_EN
        logic [31:0] p_s, p_l;
`endif
        do_reset();
`ifdef SCOREBOARD_PERF_EN
        p_s = perf_stall_cycles; p_l = perf_load_stalls;
`endif
        drv(1, 7, 1, 1, 0, 0, 0, 0, 0); cycle();
        drv(1, 8, 1, 0, 0, 7, 0, 1, 0);
        n_checks++;
        if (stall !== 1'b1 || busy_mask[7] !== 1'b1) begin
            n_fail++; $display("FAIL load_c1: stall=%b busy7=%b want 1/1", stall, busy_mask[7]);
        end
        cycle();
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL load_c2: stall=%b want 1", stall); end
        cycle();
        n_checks++;
        if (stall !== 1'b0 || busy_mask[7] !== 1'b0) begin
            n_fail++; $display("FAIL load_c3: stall=%b busy7=%b want 0/0", stall, busy_mask[7]);
        end
        cycle();
        idle();
        n_checks++;
        if (busy_mask !== 32'h100) begin n_fail++; $display("FAIL load_c4_mask: busy=%h want 00000100", busy_mask); end
`ifdef SCOREBOARD_PERF_EN
        n_checks++;
        if (perf_stall_cycles - p_s !== 32'd2 || perf_load_stalls - p_l !== 32'd2) begin
            n_fail++;
            $display("FAIL load_perf: delta %0d/%0d want 2/2", perf_stall_cycles - p_s, perf_load_stalls - p_l);
        end
`endif
    endtask

    task automatic test_x0_unused();
        do_reset();
        drv(1, 0, 1, 1, 0, 0, 0, 0, 0); cycle();
        drv(1, 3, 1, 0, 0, 0, 1, 1, 0);
        n_checks++;
        if (stall !== 1'b0 || busy_mask !== 32'h0) begin
            n_fail++; $display("FAIL x0_read: stall=%b busy=%h want 0/0", stall, busy_mask);
        end
        do_reset();
        drv(1, 5, 1, 1, 0, 0, 0, 0, 0); cycle();
        drv(1, 6, 1, 0, 5, 3, 0, 1, 0);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL unused_src: stall=%b want 0", stall); end
        drv(1, 6, 0, 0, 0, 5, 0, 1, 0);
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL used_rs2: stall=%b want 1", stall); end
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL write_only: stall=%b want 0", stall); end
        idle(); cycle();
    endtask

    task automatic test_flush_undo();
        do_reset();
        drv(1, 9, 1, 1, 0, 0, 0, 0, 0); cycle();
        drv(1, 9, 1, 0, 9, 0, 1, 0, 0);
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_reissue_block: stall=%b want 1", stall); end
        idle(); cycle();
        drv(1, 9, 1, 1, 0, 0, 0, 0, 0); cycle();
        drv(1, 12, 1, 0, 9, 0, 1, 0, 1);
        n_checks++;
        if (stall !== 1'b0 || busy_mask[9] !== 1'b1) begin
            n_fail++; $display("FAIL flush_cycle: stall=%b busy9=%b want 0/1", stall, busy_mask[9]);
        end
        cycle();
        drv(1, 13, 1, 0, 9, 0, 1, 0, 0);
        n_checks++;
        if (stall !== 1'b0 || busy_mask !== 32'h0) begin
            n_fail++; $display("FAIL flush_restore0: stall=%b busy=%h want 0/00000000", stall, busy_mask);
        end
        idle(); cycle();
        // undo restores the older load's remaining time, not zero
        do_reset();
        drv(1, 9, 1, 1, 0, 0, 0, 0, 0); cycle();
        drv(1, 9, 1, 0, 0, 0, 0, 0, 0); cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
        drv(1, 14, 1, 0, 9, 0, 1, 0, 0);
        n_checks++;
        if (stall !== 1'b1 || busy_mask !== 32'h200) begin
            n_fail++; $display("FAIL flush_restore_old: stall=%b busy=%h want 1/00000200", stall, busy_mask);
        end
        cycle();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_release: stall=%b want 0", stall); end
        idle(); cycle();
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 5) == 0);
            n_checks++;
            if (stall !== m_stall() || busy_mask !== m_mask()) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL random_c%0d: stall=%b busy=%h want %b/%h", i, stall, busy_mask, m_stall(), m_mask());
            end
`ifdef SCOREBOARD_PERF_EN
            n_checks++;
            if (perf_stall_cycles !== 32'(m_pstall) || perf_load_stalls !== 32'(m_pload)) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL random_perf_c%0d: got %0d/%0d want %0d/%0d", i,
                             perf_stall_cycles, perf_load_stalls, m_pstall, m_pload);
            end
`endif
            cycle();
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_use();
        test_load_use();
        test_x0_unused();
        test_flush_undo();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the MEM/WB forwarding logic. Forwarding only covers a producer that has reached MEM/WB, so this block tracks destination registers issued from ID that are not yet forwardable.
- It asserts a stall to hold IF/ID (and bubble ID/EX) whenever the instruction in ID reads such a register.
- Sits beside the ID stage. It is fed by decode and by the EX-stage branch flush.

Parameters:
- ALU_LAT, 1, cycles after issue until an ALU result is forwardable to an instruction in ID.
- LOAD_LAT, 2, cycles after issue until load data is forwardable to an instruction in ID.
- CW, 3, width of each per-register countdown; must hold max(ALU_LAT, LOAD_LAT).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- issue_valid  in  1  valid instruction in ID.
- issue_rd  in  5  destination register of the ID instruction.
- issue_we  in  1  ID instruction writes a register (RegWrite).
- issue_is_load  in  1  ID instruction is a load.
- issue_rs1, issue_rs2  in  5 each  source registers.
- issue_rs1_used, issue_rs2_used  in  1 each  source actually read.
- flush  in  1  branch taken in EX; squash the ID instruction and the instruction issued last cycle.
- stall  out  1  hold PC and IF/ID, insert a bubble into ID/EX.
- busy_mask  out  32  bit r = cnt[r] != 0; bit 0 is always 0.

Behaviour:
- **State**
  - cnt[1..31], each CW bits; 0 means ready.
  - Undo record: last_valid (1 bit), last_rd (5 bits), last_prev (CW bits).
  - Register x0 is never tracked.
- **Reset** (asynchronous, rst=1): all cnt=0, last_valid=0, so stall=0 and busy_mask=0 immediately. Reset asserted mid-stall drops stall the same instant.
- **stall** (combinational, zero latency)
  - stall = issue_valid & !flush & ((issue_rs1_used & rs1!=0 & cnt[rs1]!=0) | (issue_rs2_used & rs2!=0 & cnt[rs2]!=0)).
  - A write-only instruction never stalls.
- **issue_fire** = issue_valid & !stall & !flush & issue_we & (issue_rd!=0).
- **Per-cycle update**, in priority order:
  1. Every nonzero cnt decrements by 1, saturating at 0.
  2. If flush & last_valid: cnt[last_rd] <= sat_dec(last_prev). This undoes the squashed issue and restores the older writer's remaining time. It overrides step 1 for that entry.
  3. If issue_fire: cnt[issue_rd] <= issue_is_load ? LOAD_LAT : ALU_LAT. This overrides steps 1 and 2 for that entry. It cannot coincide with step 2, because issue_fire requires !flush.
- **Undo record**
  - On issue_fire: last_valid<=1, last_rd<=issue_rd, last_prev<=cnt[issue_rd] (value before update).
  - Otherwise: last_valid<=0.
  - Undo therefore reaches back exactly one cycle.
- **Stall resolution**: a stalled instruction re-evaluates every cycle. With default parameters:
  - back-to-back dependent ALU op stalls 1 cycle;
  - dependent op after a load stalls 2 cycles;
  - distance ≥ LOAD_LAT+1 never stalls.
- **Same-register reissue**: newest issue wins; its countdown replaces the older one. This is safe because the newer writer always finishes later or equal.
- **Simultaneous events**
  - flush with an issue_valid instruction: no stall, no issue; that instruction is squashed.
  - Stall while counters decrement: allowed. Counters run freely; they are never frozen by stall.

Optional Feature:
- Macro: SCOREBOARD_PERF_EN.
- When defined, adds two 32-bit outputs:
  - perf_stall_cycles: +1 each cycle stall=1.
  - perf_load_stalls: +1 each cycle stall=1 and the blocking source's owner was a load. This requires one extra bit per register, is_load[r], set at issue_fire.
- Both counters wrap at 2^32, reset to 0, and hold during rst.
- When undefined: ports and is_load bits are absent; all other behaviour is identical.

Test Plan:
- **Reset**: assert rst for 3 cycles with random inputs -> stall=0, busy_mask=0 throughout; deassert, then issue x5 ALU -> next cycle busy_mask=32'h0000_0020.
- **ALU-use**: cycle0 issue add x5; cycle1 issue sub rs1=x5 -> stall=1 in cycle1 only, issued cycle2; with one unrelated instruction between -> no stall.
- **Load-use**: cycle0 lw x7; cycle1 add rs2=x7 -> stall=1 in cycles 1 and 2, issued cycle3, busy_mask bit7 clears at cycle3.
- **x0 and unused sources**: issue add x0 then a reader of x0 -> no stall, busy_mask=0; reader of x5 with rs1_used=0 while x5 busy -> no stall.
- **Flush undo**:
  - lw x9 (cnt=2); next cycle add x9 reissue blocked by stall.
  - Alternatively, issue ALU x9 when cnt[x9]=1, then flush next cycle -> cnt[x9] restored to 0 and stall on x9 readers is released.
  - flush with issue_valid on an x9 reader -> stall=0, nothing marked.
- **Perf (SCOREBOARD_PERF_EN)**: load-use sequence above -> perf_stall_cycles=2, perf_load_stalls=2; ALU-use -> perf_stall_cycles increments by 1, perf_load_stalls unchanged.
